// File: rtl/smg_scan_driver_if.sv
// rtl/smg_scan_driver_if.sv - display data in / digit+segment pins out bundle for smg_scan_driver
interface smg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     dig;
  logic [7:0]            smg;
  logic                  frame_done;

  modport master (
    output enable, data_in, dp_in, blank_in,
    input  dig, smg, frame_done
  );

  modport slave (
    input  enable, data_in, dp_in, blank_in,
    output dig, smg, frame_done
  );
endinterface

// File: rtl/smg_scan_driver.sv
// rtl/smg_scan_driver.sv - multiplexed common-anode 7-seg scan driver with dead time and frame snapshot
// Optional leading-zero suppression: define SMG_LEADING_ZERO_BLANK_EN.
module smg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  smg_scan_driver_if.slave   bus_if
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] DEAD     = CW'(DEAD_CYCLES);
  localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [7:0]          smg_q, smg_d;
  logic                fd_q, fd_d;
  logic                slot_end;
  logic                snap;
  logic [3:0]          nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h01;
      4'h1: seg_decode = 7'h4F;
      4'h2: seg_decode = 7'h12;
      4'h3: seg_decode = 7'h06;
      4'h4: seg_decode = 7'h4C;
      4'h5: seg_decode = 7'h24;
      4'h6: seg_decode = 7'h20;
      4'h7: seg_decode = 7'h0F;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h04;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h60;
      4'hC: seg_decode = 7'h31;
      4'hD: seg_decode = 7'h42;
      4'hE: seg_decode = 7'h30;
      default: seg_decode = 7'h38;
    endcase
  endfunction

  assign slot_end = (cnt_q == CNT_LAST);
  // Frame start: shadow registers reload only here, so a frame never tears
  assign snap     = bus_if.enable && (cnt_q == '0) && (idx_q == '0);
  assign nib      = data_q[{idx_q, 2'b00} +: 4];

`ifdef SMG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_q, lz_d;
  logic              lead;

  always_comb begin
    lz_d = lz_q;
    lead = 1'b1;
    if (snap) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        lead    = lead && (bus_if.data_in[4*i +: 4] == 4'h0);
        lz_d[i] = lead;
      end
      lz_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lz_q <= '0;
    else     lz_q <= lz_d;
  end
`endif

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (!bus_if.enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (snap) begin
      data_d  = bus_if.data_in;
      dp_d    = bus_if.dp_in;
      blank_d = bus_if.blank_in;
    end
  end

  always_comb begin
    dig_d = '0;
    smg_d = 8'hFF;
    fd_d  = bus_if.enable && slot_end && (idx_q == IDX_LAST);
    // Dead time at the head of each slot keeps ghosting off between digits
    if (bus_if.enable && (cnt_q >= DEAD)) begin
      dig_d = ONE_HOT0 << idx_q;
      if (blank_q[idx_q])
        smg_d = 8'hFF;
`ifdef SMG_LEADING_ZERO_BLANK_EN
      else if (lz_q[idx_q])
        smg_d = {~dp_q[idx_q], 7'h7F};
`endif
      else
        smg_d = {~dp_q[idx_q], seg_decode(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      dig_q   <= '0;
      smg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      dig_q   <= dig_d;
      smg_q   <= smg_d;
      fd_q    <= fd_d;
    end
  end

  assign bus_if.dig        = dig_q;
  assign bus_if.smg        = smg_q;
  assign bus_if.frame_done = fd_q;
endmodule

// File: tb/tb_smg_scan_driver.sv
// tb/tb_smg_scan_driver.sv - randomized scoreboard bench for smg_scan_driver
module tb_smg_scan_driver;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  smg_scan_driver_if #(.DIGITS(DIGITS)) bus_if ();

  smg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .rst(rst), .bus_if(bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fd = -1;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Reference: t counts enabled edges since the scan (re)started
  int          t = 0;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp, sh_blank, sh_lz;
  logic [3:0]  exp_dig;
  logic [7:0]  exp_smg;
  logic        exp_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int pos, slot;
    bit lead;
    exp_dig = '0;
    exp_smg = 8'hFF;
    exp_fd  = 1'b0;
    if (rst) begin
      t = 0; sh_data = '0; sh_dp = '0; sh_blank = '0; sh_lz = '0;
      last_fd = -1;
    end else if (!bus_if.enable) begin
      t = 0;
      last_fd = -1;
    end else begin
      pos  = t % SCAN_DIV;
      slot = (t / SCAN_DIV) % DIGITS;
      if (t % FRAME == 0) begin
        sh_data  = bus_if.data_in;
        sh_dp    = bus_if.dp_in;
        sh_blank = bus_if.blank_in;
        sh_lz    = '0;
`ifdef SMG_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
          lead = lead && (sh_data[d*4 +: 4] == 4'h0);
          sh_lz[d] = lead;
        end
`endif
      end
      exp_fd = (pos == SCAN_DIV - 1) && (slot == DIGITS - 1);
      if (pos >= DEAD) begin
        exp_dig = 4'(1 << slot);
        if (sh_blank[slot])   exp_smg = 8'hFF;
        else if (sh_lz[slot]) exp_smg = {~sh_dp[slot], 7'h7F};
        else                  exp_smg = {~sh_dp[slot], seg_tab[sh_data[slot*4 +: 4]]};
      end
      t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("dig", bus_if.dig, exp_dig);
    check("smg", bus_if.smg, exp_smg);
    check("frame_done", bus_if.frame_done, exp_fd);
    check("dig_onehot0", $onehot0(bus_if.dig), 1);
    if (bus_if.frame_done) begin
      if (last_fd >= 0) check("frame_period", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pos(input int slot, input int pos);
    int ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (t % FRAME == slot * SCAN_DIV + pos) begin ok = 1; break; end
      tick();
    end
    if (ok == 0) check("wait_pos_timeout", 0, 1);
  endtask

  initial begin
    bus_if.enable = 1'b0; bus_if.data_in = '0; bus_if.dp_in = '0; bus_if.blank_in = '0;
    rst = 1'b1;
    run(2);
    check("rst_dig", bus_if.dig, 0);
    check("rst_smg", bus_if.smg, 8'hFF);
    check("rst_fd", bus_if.frame_done, 0);
    rst = 1'b0;

    bus_if.enable = 1'b1; bus_if.data_in = 16'h1234;
    run(2 * FRAME + 3);

    wait_pos(2, 3);
    bus_if.data_in = 16'hABCD;
    run(2 * FRAME);

    bus_if.dp_in = 4'b0100; bus_if.blank_in = 4'b0001;
    run(2 * FRAME);

    wait_pos(1, 4);
    bus_if.enable = 1'b0;
    run(5);
    bus_if.data_in = 16'h5E07; bus_if.dp_in = 4'b1001; bus_if.blank_in = 4'b0000;
    bus_if.enable = 1'b1;
    run(FRAME + 4);

    wait_pos(3, 4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(FRAME + 2);

`ifdef SMG_LEADING_ZERO_BLANK_EN
    bus_if.dp_in = '0;
    bus_if.data_in = 16'h0070;
    run(2 * FRAME);
    bus_if.data_in = 16'h0000; bus_if.dp_in = 4'b0010;
    run(2 * FRAME);
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        bus_if.data_in  = 16'($urandom);
        if ($urandom_range(1) == 0) bus_if.data_in[15:8] = 8'h00;
        bus_if.dp_in    = 4'($urandom);
        bus_if.blank_in = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      end
      if (bus_if.enable == 1'b0)            bus_if.enable = ($urandom_range(3) == 0);
      else if ($urandom_range(60) == 0)     bus_if.enable = 1'b0;
      rst = ($urandom_range(250) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
